// File: rtl/vic_sound_pkg.sv
// Shared constants and helpers for the VIC-style sound generator.
// Register map offsets, channel register fields and LFSR definition.
package vic_sound_pkg;

   localparam int ENABLE_BIT = 7;
   localparam logic [15:0] LFSR_SEED = 16'h0001;
   // Taps 16,15,13,4 (1-based) -> bits 15,14,12,3
   localparam logic [15:0] LFSR_TAPS = 16'hD008;

   function automatic int tone_addr(int k);
      return k;
   endfunction

   function automatic int noise_addr(int n_tone);
      return n_tone;
   endfunction

   function automatic int amp_addr(int n_tone);
      return n_tone + 1;
   endfunction

   // Left-shifting Fibonacci step; an all-zero state reseeds.
   function automatic logic [15:0] lfsr_next(logic [15:0] s);
      if (s == 16'h0000)
         return LFSR_SEED;
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/vic_sound_chan.sv
// One sound channel: 7-bit up-counter with reload and square toggle.
// Reload pulse is exposed so the noise channel can clock its LFSR.
module vic_sound_chan (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       enable,
   input  logic [6:0] freq,
   output logic       square,
   output logic       reload
);

   logic [6:0] cnt;

   assign reload = enable & tick & (cnt == 7'h7F);

   // Count up on ticks, reload and toggle at 7F; idle holds F and low output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= 7'h00;
         square <= 1'b0;
      end else if (!enable) begin
         cnt    <= freq;
         square <= 1'b0;
      end else if (tick) begin
         if (cnt == 7'h7F) begin
            cnt    <= freq;
            square <= ~square;
         end else begin
            cnt <= cnt + 7'd1;
         end
      end
   end

endmodule

// File: rtl/vic_sound_gen.sv
// Parametrised VIC-20 style sound generator: NUM_TONE square tones,
// one LFSR noise channel, master amplitude and registered mixer.
module vic_sound_gen
   import vic_sound_pkg::*;
#(
   parameter int NUM_TONE      = 3,
   parameter int PRESCALE_LOG2 = 2,
   parameter int OUT_W         = 6,
   parameter int ADDR_W        = $clog2(NUM_TONE + 2)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ena4,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_din,
   output logic [7:0]        o_dout,
   output logic [NUM_TONE:0] o_chan,
   output logic [OUT_W-1:0]  o_audio
);

   localparam int NCH = NUM_TONE + 1;
   localparam int PW  = PRESCALE_LOG2 + NUM_TONE - 1;
   localparam int SW  = $clog2(NCH + 1);
   localparam int NZ  = noise_addr(NUM_TONE);
   localparam logic [ADDR_W-1:0] AMP_A = ADDR_W'(amp_addr(NUM_TONE));

   logic [7:0]     regs [NCH];
   logic [3:0]     amp;
   logic [PW-1:0]  presc;
   logic [15:0]    lfsr;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] sq;
   logic [NCH-1:0] rl;
   logic [NCH-1:0] chan_bits;
   logic [SW-1:0]  sum;
   logic           unused_bits;

   // Register file: channel registers and amplitude, written on i_we
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < NCH; k++)
            regs[k] <= 8'h00;
         amp <= 4'h0;
      end else if (i_we) begin
         for (int k = 0; k < NCH; k++)
            if (i_addr == ADDR_W'(tone_addr(k)))
               regs[k] <= i_din;
         if (i_addr == AMP_A)
            amp <= i_din[3:0];
      end
   end

   // Combinational readback; unmapped addresses read zero
   always_comb begin
      o_dout = 8'h00;
      for (int k = 0; k < NCH; k++)
         if (i_addr == ADDR_W'(tone_addr(k)))
            o_dout = regs[k];
      if (i_addr == AMP_A)
         o_dout = {4'h0, amp};
   end

   // Free-running prescaler advanced by the sound enable strobe
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         presc <= '0;
      else if (i_ena4)
         presc <= presc + PW'(1);
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      localparam int S = (k < NUM_TONE) ?
                         (PRESCALE_LOG2 + NUM_TONE - 1 - k) :
                         PRESCALE_LOG2;

      assign tick[k] = i_ena4 & (&presc[S-1:0]);

      vic_sound_chan u_chan (
         .clk    (i_clk),
         .reset  (i_reset),
         .tick   (tick[k]),
         .enable (regs[k][ENABLE_BIT]),
         .freq   (regs[k][6:0]),
         .square (sq[k]),
         .reload (rl[k])
      );
   end

   // Noise LFSR steps on every reload of the noise counter
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         lfsr <= LFSR_SEED;
      else if (rl[NZ])
         lfsr <= lfsr_next(lfsr);
   end

   assign chan_bits = {lfsr[0] & regs[NZ][ENABLE_BIT],
                       sq[NUM_TONE-1:0]};
   assign o_chan = chan_bits;

   // Noise square and tone reload pulses carry no output meaning
   assign unused_bits = ^{sq[NZ], rl[NUM_TONE-1:0]};

   // Count active channel bits
   always_comb begin
      sum = '0;
      for (int k = 0; k < NCH; k++)
         sum = sum + SW'(chan_bits[k]);
   end

   // Registered mixer, updated every clock
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         o_audio <= '0;
      else
         o_audio <= OUT_W'(sum) * OUT_W'(amp);
   end

endmodule

// File: doc/vic_sound_gen.md
Name: vic_sound_gen

Overview:
Parametrised successor to the VIC-20 sound generator. It provides NUM_TONE square-wave tone channels plus one LFSR noise channel, a 4-bit master amplitude, and a registered mixed output.
- Sits on the CPU bus beside the VIAs at $900A upward and is clocked by the 4x enable strobe.
- Adds register readback, a per-channel activity vector and a configurable channel count and output width, none of which the fixed 3-tone generator has.

Parameters:
NUM_TONE, 3, number of tone channels; channel 0 is lowest pitch (bass), channel NUM_TONE-1 is highest (soprano)
PRESCALE_LOG2, 2, log2 of the enable-pulse divider for the highest tone channel; must be >= 1
OUT_W, 6, mixed output width; must be >= clog2((NUM_TONE+1)*15+1)
ADDR_W, clog2(NUM_TONE+2), register address width

Ports:
i_clk  in  1  system clock (25 MHz)
i_reset  in  1  asynchronous active-high reset
i_ena4  in  1  sound clock-enable strobe, one i_clk cycle wide
i_we  in  1  register write strobe, sampled each i_clk
i_addr  in  ADDR_W  register select: 0..NUM_TONE-1 = tone, NUM_TONE = noise, NUM_TONE+1 = amplitude
i_din  in  8  write data
o_dout  out  8  combinational readback of the register at i_addr; amplitude reads as {4'b0, amp}; out-of-range address reads 8'h00
o_chan  out  NUM_TONE+1  current channel output bits {noise, tone[NUM_TONE-1:0]}
o_audio  out  OUT_W  mixed output, registered

Behaviour:
- Reset (asynchronous, active-high):
  - All channel registers and the amplitude clear to 0.
  - Counters clear to 0, square outputs clear to 0, prescaler clears to 0.
  - LFSR loads 16'h0001.
  - o_audio and o_chan read 0.
- Register write: when i_we is high, the addressed register takes i_din on that edge.
  - Channel register format: bit7 = enable, bits[6:0] = frequency F.
  - A write does not restart a running counter. The new F takes effect at the next reload.
- Prescaler:
  - Free-running counter of PRESCALE_LOG2+NUM_TONE-1 bits, increments on i_ena4 and wraps.
  - Channel k uses shift S_k = PRESCALE_LOG2 + NUM_TONE-1-k.
  - tick_k = i_ena4 AND the prescaler's low S_k bits are all ones.
  - The noise channel uses S_{NUM_TONE-1}, the same rate as the highest tone.
- Channel counter (7 bits, one per tone channel and one for noise):
  - Enable = 0: counter loads F every cycle; square is forced to 0 on the next edge.
  - Enable = 1 on tick_k: if counter == 7'h7F, reload F and toggle the square; else counter+1.
  - Resulting half-period = 128-F ticks. F = 7F toggles every tick; F = 0 toggles every 128 ticks.
  - Enable rising edge: counter begins from the F loaded while disabled, with no glitch.
- Noise:
  - 16-bit Fibonacci LFSR, taps 16,15,13,4 (maximal length).
  - Shifts once each time the noise counter reloads while enabled.
  - Noise output bit = LFSR[0] ANDed with enable.
  - If the LFSR ever reads all-zero, it loads 16'h0001 on the next shift (lock-up guard).
- Mixer:
  - sum = popcount(o_chan), range 0..NUM_TONE+1.
  - o_audio <= sum * amp, zero-extended to OUT_W, registered every i_clk (not gated by i_ena4).
  - Latency is one cycle from a channel-bit or amplitude change to o_audio.
- Simultaneous events:
  - A write and a tick on the same edge: the tick uses the old register value; the new value is visible next cycle.
  - A write to the amplitude register is reflected in o_audio two edges later (register, then mixer).
- Reset asserted mid-period: everything returns to reset values immediately, without waiting for a clock. On release, operation resumes from the reset state.

Decomposition:
- Shared package vic_sound_pkg:
  - register address offsets (function of NUM_TONE)
  - ENABLE_BIT = 7
  - LFSR_SEED = 16'h0001
  - LFSR tap mask
- One natural sub-module, vic_sound_chan: counter, square toggle and reload pulse output, parametrised by nothing beyond its tick input.
  - Instantiated NUM_TONE+1 times via generate.
  - The noise instance's reload pulse drives the LFSR.

Test Plan:
- Reset with all registers written first → after i_reset, o_audio=0, o_chan=0, all readbacks 8'h00, noise readback 8'h00.
- i_ena4 tied high, defaults, tone2 (reg 2) = 8'hFE, amp = 4'hF → o_chan[2] toggles every 8 i_clk cycles; o_audio alternates 0 and 15.
- Tone0 = 8'hFF with PRESCALE_LOG2=2 → tone0 ticks every 16 cycles and toggles every tick (period 32 cycles); clearing bit7 → o_chan[0]=0 on the next edge.
- All three tones F=7F enabled, noise = 8'hFF, amp = 15 → sample a cycle where o_chan=4'b1111 and check o_audio=6'h3C; then amp=0 → o_audio=0 two edges after the write.
- Noise enabled, F=7F → LFSR sequence from 0001 matches the reference polynomial for 64 shifts; o_chan[3] = LFSR[0].
- Write tone1 mid-period from 8'hF0 to 8'hFC while the counter is at 7A → current half-period completes at 128-0x70=16 ticks; the next half-period is 4 ticks. Then assert i_reset mid-period → o_chan and o_audio go to 0 asynchronously.
